// File: rtl/cm0_pmu_cdc_send_bus.sv
// Source-side CDC launch register for a WIDTH-bit word, handshaking with an
// unrelated receive domain in four-phase (MODE 0) or two-phase toggle (MODE 1) signalling.
module cm0_pmu_cdc_send_bus #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      MODE        = 0
) (
    input  logic             REGCLK,
    input  logic             REGRESETn,
    input  logic             SENDVALID,
    input  logic [WIDTH-1:0] SENDDATA,
    output logic             SENDREADY,
    output logic [WIDTH-1:0] REGDO,
    output logic             REQ,
    input  logic             ACKASYNC,
    output logic             DONE,
    output logic             PROTERR
);

    localparam bit TOGGLE = (MODE != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_TG = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     req_q, req_d;
    logic                     done_q, done_d;
    logic                     proterr_q, proterr_d;
    logic [WIDTH-1:0]         regdo_q;
    logic [SYNC_STAGES-1:0]   ack_sync;
    logic                     ack_s;
    logic                     idle_lvl;
    logic                     ack_ok;
    logic                     ready;
    logic                     accept;

    // Acknowledge synchroniser; only its last stage is ever looked at.
    always_ff @(posedge REGCLK) begin
        if (!REGRESETn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ACKASYNC};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // In toggle mode the quiescent acknowledge level tracks REQ; in
    // return-to-zero mode both lines rest low between transfers.
    assign idle_lvl = TOGGLE ? req_q : 1'b0;
    assign ack_ok   = (ack_s == idle_lvl);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        done_d    = 1'b0;
        proterr_d = proterr_q;
        ready     = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                // Hold off for the DONE cycle so completion and acceptance never coincide.
                ready  = ack_ok & ~done_q;
                accept = ready & SENDVALID;
                if (!ack_ok) begin
                    proterr_d = 1'b1;
                end
                if (accept) begin
                    if (TOGGLE) begin
                        req_d   = ~req_q;
                        state_d = WAIT_TG;
                    end else begin
                        req_d   = 1'b1;
                        state_d = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_TG: begin
                if (ack_s == req_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge REGCLK) begin
        if (!REGRESETn) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            proterr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            done_q    <= done_d;
            proterr_q <= proterr_d;
        end
    end

    // Launch register: loads only on acceptance so the receiver never sees it move mid-handshake.
    always_ff @(posedge REGCLK) begin
        if (!REGRESETn) begin
            regdo_q <= RESET_VAL;
        end else if (accept) begin
            regdo_q <= SENDDATA;
        end
    end

    assign SENDREADY = ready;
    assign REGDO     = regdo_q;
    assign REQ       = req_q;
    assign DONE      = done_q;
    assign PROTERR   = proterr_q;

`ifdef ARM_ASSERT_ON
    a_send_known: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
        SENDREADY |-> !$isunknown({SENDVALID, SENDDATA}));
    a_done_not_accept: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
        !(DONE && accept));
`endif

endmodule

// File: tb/tb_cm0_pmu_cdc_send_bus.sv
// Bench for cm0_pmu_cdc_send_bus: one four-phase and one toggle instance run
// side by side against a transaction-level handshake model plus directed literal checks.
module tb_cm0_pmu_cdc_send_bus;

    localparam int          S  = 2;
    localparam logic [7:0]  RV = 8'hA5;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0, v1, ack0, ack1;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1, req0, req1, done0, done1, err0, err1;
    logic [7:0] do0, do1;

    cm0_pmu_cdc_send_bus #(.WIDTH(8), .RESET_VAL(RV), .SYNC_STAGES(S), .MODE(0)) u_dut0 (
        .REGCLK(clk), .REGRESETn(rst_n), .SENDVALID(v0), .SENDDATA(d0), .SENDREADY(rdy0),
        .REGDO(do0), .REQ(req0), .ACKASYNC(ack0), .DONE(done0), .PROTERR(err0)
    );

    cm0_pmu_cdc_send_bus #(.WIDTH(8), .RESET_VAL(RV), .SYNC_STAGES(S), .MODE(1)) u_dut1 (
        .REGCLK(clk), .REGRESETn(rst_n), .SENDVALID(v1), .SENDDATA(d1), .SENDREADY(rdy1),
        .REGDO(do1), .REQ(req1), .ACKASYNC(ack1), .DONE(done1), .PROTERR(err1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction view: a word is outstanding (busy) from acceptance until the
    // synchronised acknowledge settles at the REQ level; four-phase first drops REQ
    // once the acknowledge has risen.
    typedef struct packed {
        logic [7:0]   dout;
        logic         req;
        logic         busy;
        logic         done;
        logic         err;
        logic [S-1:0] hist;
    } mdl_t;

    mdl_t m0, m1;
    bit   mdl_ok = 1'b0;

    function automatic mdl_t step(input mdl_t s, input bit toggle, input logic rstn,
                                  input logic valid, input logic [7:0] data, input logic ack);
        mdl_t n;
        logic acks;
        logic rdy;
        n = s;
        if (!rstn) begin
            n.dout = RV;
            n.req  = 1'b0;
            n.busy = 1'b0;
            n.done = 1'b0;
            n.err  = 1'b0;
            n.hist = '0;
            return n;
        end
        acks   = s.hist[S-1];
        rdy    = !s.busy && !s.done && (acks == s.req);
        n.done = 1'b0;
        if (!s.busy && acks != s.req) n.err = 1'b1;
        if (rdy && valid) begin
            n.dout = data;
            n.req  = toggle ? !s.req : 1'b1;
            n.busy = 1'b1;
        end else if (s.busy) begin
            if (!toggle && s.req && acks) begin
                n.req = 1'b0;
            end else if (acks == s.req) begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end
        end
        n.hist = {s.hist[S-2:0], ack};
        return n;
    endfunction

    function automatic logic mrdy(input mdl_t s);
        return !s.busy && !s.done && (s.hist[S-1] == s.req);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m0 = step(m0, 1'b0, rst_n, v0, d0, ack0);
            m1 = step(m1, 1'b1, rst_n, v1, d1, ack1);
            if (!rst_n) mdl_ok = 1'b1;
            @(negedge clk);
            if (mdl_ok) begin
                check("m0_regdo",  32'(do0),   32'(m0.dout));
                check("m0_req",    32'(req0),  32'(m0.req));
                check("m0_done",   32'(done0), 32'(m0.done));
                check("m0_proterr",32'(err0),  32'(m0.err));
                check("m0_ready",  32'(rdy0),  32'(mrdy(m0)));
                check("m1_regdo",  32'(do1),   32'(m1.dout));
                check("m1_req",    32'(req1),  32'(m1.req));
                check("m1_done",   32'(done1), 32'(m1.done));
                check("m1_proterr",32'(err1),  32'(m1.err));
                check("m1_ready",  32'(rdy1),  32'(mrdy(m1)));
            end
        end
    end

    bit       echo = 1'b0;
    bit       rnd0 = 1'b0;
    bit [2:0] echo_hist = '0;
    int       done1_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (done1) done1_cnt++;
        if (echo) begin
            echo_hist = {echo_hist[1:0], req1};
            ack1      = echo_hist[2];
        end
        if (rnd0) d0 = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; ack0 = 1'b0; ack1 = 1'b0;

        repeat (3) tick();
        check("t1_regdo",   32'(do0),   32'h0A5);
        check("t1_req",     32'(req0),  32'h0);
        check("t1_ready",   32'(rdy0),  32'h1);
        check("t1_done",    32'(done0), 32'h0);
        check("t1_proterr", 32'(err0),  32'h0);
        check("t1_regdo1",  32'(do1),   32'h0A5);
        rst_n = 1'b1;
        repeat (2) tick();

        // Four-phase transfer with the source hammering SENDDATA while busy.
        v0 = 1'b1; d0 = 8'h3C;
        tick();
        check("t2_accept_regdo", 32'(do0),  32'h03C);
        check("t2_accept_req",   32'(req0), 32'h1);
        check("t2_busy_ready",   32'(rdy0), 32'h0);
        rnd0 = 1'b1;
        d0 = 8'($urandom);
        repeat (3) begin
            tick();
            check("t3_hold_regdo", 32'(do0),  32'h03C);
            check("t3_hold_req",   32'(req0), 32'h1);
            check("t3_hold_ready", 32'(rdy0), 32'h0);
        end
        ack0 = 1'b1;
        tick(); check("t2_req_M",   32'(req0), 32'h1);
        tick(); check("t2_req_M1",  32'(req0), 32'h1);
        tick(); check("t2_req_M2",  32'(req0), 32'h0);
        check("t3_regdo_M2", 32'(do0), 32'h03C);
        repeat (2) begin
            tick();
            check("t3_lo_req",   32'(req0),  32'h0);
            check("t3_lo_ready", 32'(rdy0),  32'h0);
            check("t3_lo_done",  32'(done0), 32'h0);
        end
        ack0 = 1'b0;
        tick(); check("t2_done_K",  32'(done0), 32'h0);
        tick(); check("t2_done_K1", 32'(done0), 32'h0);
        tick(); check("t2_done_K2", 32'(done0), 32'h1);
        check("t2_ready_K2", 32'(rdy0), 32'h0);
        tick(); check("t2_done_K3", 32'(done0), 32'h0);
        check("t2_ready_K3", 32'(rdy0), 32'h1);
        check("t3_regdo_end", 32'(do0), 32'h03C);
        rnd0 = 1'b0;
        v0 = 1'b0;
        repeat (2) tick();

        // Spurious acknowledge in IDLE.
        ack0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) check("t5_ready_low", 32'(rdy0), 32'h0);
            if (i == 2) check("t5_proterr",   32'(err0), 32'h1);
            if (i == 3) ack0 = 1'b0;
        end
        check("t5_ready_back", 32'(rdy0), 32'h1);
        check("t5_sticky",     32'(err0), 32'h1);
        check("t5_req",        32'(req0), 32'h0);
        check("t5_regdo",      32'(do0),  32'h03C);

        // Toggle-mode back-to-back with an echoing receiver.
        echo = 1'b1;
        done1_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            v1 = 1'b1;
            d1 = 8'(i + 1);
            waited = 0;
            while (!rdy1 && waited < 40) begin
                tick();
                waited++;
            end
            check("t4_ready_seen", 32'(waited < 40), 32'h1);
            tick();
            check("t4_regdo", 32'(do1),  32'(i + 1));
            check("t4_req",   32'(req1), 32'((i % 2) == 0));
            v1 = 1'b0;
        end
        waited = 0;
        while (done1_cnt < 3 && waited < 40) begin
            tick();
            waited++;
        end
        check("t4_done_count", 32'(done1_cnt), 32'd3);
        check("t4_proterr",    32'(err1),      32'h0);
        check("t4_req_final",  32'(req1),      32'h1);
        check("t4_regdo_last", 32'(do1),       32'h003);
        repeat (2) tick();

        // Reset while the four-phase instance is waiting for the acknowledge.
        v0 = 1'b1; d0 = 8'h77;
        tick();
        check("t6_regdo", 32'(do0),  32'h077);
        check("t6_req",   32'(req0), 32'h1);
        v0 = 1'b0;
        tick();
        check("t6_waithi_req", 32'(req0), 32'h1);
        rst_n = 1'b0;
        echo = 1'b0;
        echo_hist = '0;
        ack1 = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_req",     32'(req0),  32'h0);
        check("t6_rst_regdo",   32'(do0),   32'h0A5);
        check("t6_rst_done",    32'(done0), 32'h0);
        check("t6_rst_proterr", 32'(err0),  32'h0);
        check("t6_rst_ready",   32'(rdy0),  32'h1);
        repeat (4) begin
            tick();
            check("t6_no_done", 32'(done0), 32'h0);
            check("t6_req_low", 32'(req0),  32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
